muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 start  in  1  EXE-stage request to begin an operation; sampled only in IDLE.
REQ-004 op  in  2  operation: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV (encodings from the package).
REQ-005 opa, opb  in  32 each  operands; for division opa is the dividend and opb the divisor.
REQ-006 hi_we, lo_we  in  1 each  MTHI/MTLO writes of wdata; accepted only in IDLE or DONE.
REQ-007 wdata  in  32  write data for hi_we/lo_we.
REQ-008 mf_req  in  1  an MFHI/MFLO instruction in EXE is requesting HI/LO.
REQ-009 busy  out  1  high in RUN.
REQ-010 done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-011 stall  out  1  pipeline freeze request.
REQ-012 div_zero  out  1  sticky flag; last division had opb==0.
REQ-013 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally, or DONE->RUN if start is high in DONE.
REQ-015 Multiply SHALL be radix-2 shift-add over 32 RUN cycles; {hi,lo} = 64-bit product.
REQ-016 Divide SHALL be restoring division over 32 RUN cycles; lo = quotient, hi = remainder.
REQ-017 Latency: with start sampled at edge N, hi/lo update at edge N+32 and done is high for the cycle after edge N+32.
REQ-018 Division with opb==0 SHALL skip RUN: IDLE->DONE at the next edge, lo=32'hFFFFFFFF, hi=opa, div_zero=1.
REQ-019 div_zero is cleared by any later accepted division with a nonzero divisor; multiply leaves it unchanged.
REQ-020 start while busy SHALL be ignored; it is not queued.
REQ-021 stall = busy & (mf_req | start | hi_we | lo_we); stall is low in DONE, so an MF in the DONE cycle reads the new result.
REQ-022 hi_we/lo_we while busy SHALL be dropped.
REQ-023 When start and hi_we/lo_we occur in the same accepted cycle, start wins and the write is dropped.
REQ-024 Operands SHALL be captured into internal registers at start acceptance; later changes on opa/opb have no effect.
REQ-025 hi/lo SHALL change only at result write, at accepted hi_we/lo_we, or at reset.

Reset
REQ-026 On rst_n==0 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, stall=0, div_zero=0, iteration counter=0.
REQ-027 Reset mid-RUN SHALL abort the operation; no done pulse follows and no partial result reaches hi/lo.

Configuration
REQ-028 Macro MULDIV_SIGNED_EN defined: MULT/DIV SHALL operate on magnitudes with sign fix-up at result write.
- Quotient sign = sign(opa) XOR sign(opb).
- Remainder sign = sign(opa).
- Latency is unchanged.
REQ-029 Macro undefined: op[0] SHALL be ignored; MULT and DIV behave as MULTU and DIVU, and no sign logic is synthesized.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the op encodings, the FSM state typedef and the ITER_COUNT=32 constant.
REQ-031 The iteration datapath (accumulator/remainder, shift register, add/subtract) SHALL be a sub-module muldiv_iter; muldiv_seq contains the FSM, counter, HI/LO and stall logic.

Verification
REQ-032 MULTU 0xFFFFFFFF*2 -> done exactly 33 cycles after start edge; hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIVU 100/7 -> lo=14, hi=2; busy high 32 cycles; done pulse exactly one cycle wide.
REQ-034 DIV 0xFFFFFFF9/2:
- With MULTDIV_SIGNED_EN: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Without MULDIV_SIGNED_EN: lo=0x7FFFFFFC, hi=1.
REQ-035 DIVU 0x1234/0 -> done one cycle after start edge; lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
- A following DIVU 8/2 clears div_zero.
REQ-036 Start MULTU 3*5, then hold mf_req high -> stall high every RUN cycle and low in DONE; lo=15 in DONE.
- Second start and lo_we=0xAA during RUN are ignored (lo stays 15).
REQ-037 rst_n=0 at iteration 10 of a MULTU -> next cycle IDLE, hi=lo=0, busy=0, and no done pulse within 40 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings, FSM state type and iteration count.
package muldiv_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath shared by multiply and divide.
// upper holds the accumulator (multiply) or partial remainder (divide);
// lower holds the multiplier being shifted out (multiply) or the dividend
// being shifted out while quotient bits shift in (divide).
// nxt_hi/nxt_lo present the state after one more step, so the owner can
// take the final result on the same edge as the last iteration.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] nxt_hi,
    output logic [DATA_W-1:0] nxt_lo
);

    logic [DATA_W-1:0] upper;
    logic [DATA_W-1:0] lower;
    logic [DATA_W-1:0] b_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] dsub;

    // One radix-2 shift-add step or one restoring-division step.
    always_comb begin
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
        shifted = {upper, lower[DATA_W-1]};
        ge      = (shifted >= {1'b0, b_q});
        // When ge holds the difference is below the divisor, so 32 bits suffice.
        dsub    = shifted[DATA_W-1:0] - b_q;
        if (div_mode) begin
            nxt_hi = ge ? dsub : shifted[DATA_W-1:0];
            nxt_lo = {lower[DATA_W-2:0], ge};
        end else begin
            nxt_hi = sum[DATA_W:1];
            nxt_lo = {sum[0], lower[DATA_W-1:1]};
        end
    end

    // Load operands at acceptance, then advance one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            upper <= '0;
            lower <= a;
            b_q   <= b;
        end else if (step) begin
            upper <= nxt_hi;
            lower <= nxt_lo;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-cycle multiply/divide unit with architectural HI/LO,
// MTHI/MTLO writes and pipeline stall generation.
// Optional feature macro: MULDIV_SIGNED_EN enables signed MULT/DIV
// (magnitude iteration with sign fix-up at result write). Without it,
// op[0] is ignored and MULT/DIV behave as MULTU/DIVU.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        mf_req,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_div;

    logic              start_ok;
    logic              is_div;
    logic              div0;
    logic              it_load;
    logic              it_step;
    logic              last_iter;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] it_hi;
    logic [DATA_W-1:0] it_lo;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    assign start_ok  = start && (state != ST_RUN);
    assign is_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign div0      = is_div && (opb == '0);
    assign it_load   = start_ok && !div0;
    assign it_step   = (state == ST_RUN);
    assign last_iter = (cnt == CNT_W'(ITER_COUNT - 1));

    // The pipeline only needs to freeze while an operation is in flight.
    assign stall = busy & (mf_req | start | hi_we | lo_we);

`ifdef MULDIV_SIGNED_EN
    logic is_sgn;
    logic neg_a;
    logic neg_b;
    logic neg_q;
    logic neg_r;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              neg);
        return neg ? -v : v;
    endfunction

    assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign neg_a  = is_sgn & opa[DATA_W-1];
    assign neg_b  = is_sgn & opb[DATA_W-1];
    assign mag_a  = magnitude(opa, neg_a);
    assign mag_b  = magnitude(opb, neg_b);

    // Remember the result signs with the operands; quotient/product sign
    // is the XOR of operand signs, remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (it_load) begin
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
        end
    end

    // Apply sign fix-up to the final iteration output.
    always_comb begin
        res_hi = it_hi;
        res_lo = it_lo;
        if (op_div) begin
            if (neg_q) res_lo = -it_lo;
            if (neg_r) res_hi = -it_hi;
        end else if (neg_q) begin
            {res_hi, res_lo} = -{it_hi, it_lo};
        end
    end
`else
    assign mag_a  = opa;
    assign mag_b  = opb;
    assign res_hi = it_hi;
    assign res_lo = it_lo;
`endif

    muldiv_iter u_iter (
        .clk      (clk),
        .load     (it_load),
        .step     (it_step),
        .div_mode (op_div),
        .a        (mag_a),
        .b        (mag_b),
        .nxt_hi   (it_hi),
        .nxt_lo   (it_lo)
    );

    // Control FSM with iteration counter, HI/LO and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_div   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (is_div) div_zero <= div0;
                        if (div0) begin
                            // Divide by zero finishes immediately with a defined result.
                            hi    <= opa;
                            lo    <= '1;
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            op_div <= is_div;
                            cnt    <= '0;
                            state  <= ST_RUN;
                            busy   <= 1'b1;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        mf_req;
    logic        busy, done, stall, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .mf_req   (mf_req),
        .busy     (busy),
        .done     (done),
        .stall    (stall),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operation definition.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic               sgn;
        logic signed [63:0] sa, sb, q, r, p;
        logic        [63:0] up;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`endif
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (o[1]) begin
            if (b == 32'd0) begin
                eh = a;
                el = 32'hFFFF_FFFF;
            end else if (sgn) begin
                q  = sa / sb;
                r  = sa % sb;
                el = q[31:0];
                eh = r[31:0];
            end else begin
                el = a / b;
                eh = a % b;
            end
        end else begin
            if (sgn) begin
                p  = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end else begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
        end
    endfunction

    // Issue one operation and wait (bounded) for done; lat counts edges
    // after the start edge until done is visible.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    int          lat, bc, scnt, k, seen;
    logic [31:0] eh, el;
    logic        dz;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'd0;
        opa    = '0;
        opb    = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        mf_req = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();

        // MULTU 0xFFFFFFFF*2: result visible after edge N+32
        run_op("mulu", 2'd0, 32'hFFFF_FFFF, 32'd2, lat, bc);
        check("mulu_lat", 64'(lat), 64'd32);
        check("mulu_busy", 64'(bc), 64'd32);
        check("mulu_hi", 64'(hi), 64'h1);
        check("mulu_lo", 64'(lo), 64'hFFFF_FFFE);

        // DIVU 100/7 with single-cycle done pulse
        tick();
        run_op("divu", 2'd2, 32'd100, 32'd7, lat, bc);
        check("divu_busy", 64'(bc), 64'd32);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        tick();
        check("divu_pulse", 64'(done), 64'd0);

        // DIV 0xFFFFFFF9/2
        run_op("div", 2'd3, 32'hFFFF_FFF9, 32'd2, lat, bc);
`ifdef MULDIV_SIGNED_EN
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
`else
        check("div_lo", 64'(lo), 64'h7FFF_FFFC);
        check("div_hi", 64'(hi), 64'h1);
`endif
        tick();

        // Divide by zero, then a clean divide clears the flag (starts from DONE)
        run_op("dz", 2'd2, 32'h1234, 32'd0, lat, bc);
        check("dz_lat", 64'(lat), 64'd0);
        check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dz_hi", 64'(hi), 64'h1234);
        check("dz_flag", 64'(div_zero), 64'd1);
        run_op("dzclr", 2'd2, 32'd8, 32'd2, lat, bc);
        check("dzclr_flag", 64'(div_zero), 64'd0);
        check("dzclr_lo", 64'(lo), 64'd4);

        // MTHI in DONE is accepted
        hi_we = 1'b1;
        wdata = 32'hCAFE_0001;
        tick();
        hi_we = 1'b0;
        check("mthi_done", 64'(hi), 64'hCAFE_0001);

        // start and hi_we together: start wins, hi untouched mid-run
        op    = 2'd2;
        opa   = 32'd10;
        opb   = 32'd3;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        check("startwin_hi", 64'(hi), 64'hCAFE_0001);
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check("startwin_done", 64'(done), 64'd1);
        check("startwin_q", 64'(lo), 64'd3);
        check("startwin_r", 64'(hi), 64'd1);
        tick();

        // MULTU 3*5 with mf_req held; stray start and lo_we during RUN
        op     = 2'd0;
        opa    = 32'd3;
        opb    = 32'd5;
        start  = 1'b1;
        mf_req = 1'b1;
        tick();
        start = 1'b0;
        scnt  = 0;
        bc    = 0;
        k     = 0;
        while (!done && k < 100) begin
            if (k == 5) begin start = 1'b1; opa = 32'd7; opb = 32'd7; end
            if (k == 6) begin start = 1'b0; lo_we = 1'b1; wdata = 32'hAA; end
            if (k == 7) lo_we = 1'b0;
            #1;
            if (busy) begin
                bc++;
                if (stall) scnt++;
            end
            tick();
            k++;
        end
        check("mf_done", 64'(done), 64'd1);
        check("mf_stall_run", 64'(scnt), 64'd32);
        check("mf_busy_run", 64'(bc), 64'd32);
        check("mf_stall_done", 64'(stall), 64'd0);
        check("mf_lo", 64'(lo), 64'd15);
        mf_req = 1'b0;
        tick();
        check("mf_noqueue", 64'(busy), 64'd0);
        check("mf_lo_keep", 64'(lo), 64'd15);

        // Reset at iteration 10 aborts the operation
        hi_we = 1'b1;
        wdata = 32'h5555;
        tick();
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h5555);
        op    = 2'd0;
        opa   = 32'd9;
        opb   = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("abort_nodone", 64'(seen), 64'd0);

        // Random operations against the reference model
        dz = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op("rnd", ro, ra, rb, lat, bc);
            model(ro, ra, rb, eh, el);
            if (ro[1]) dz = (rb == 32'd0);
            check("rnd_hi", 64'(hi), 64'(eh));
            check("rnd_lo", 64'(lo), 64'(el));
            check("rnd_dz", 64'(div_zero), 64'(dz));
            check("rnd_lat", 64'(lat), (ro[1] && rb == 32'd0) ? 64'd0 : 64'd32);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
